dispatch_operand_stage: RTL and testbench

DISPATCH_OPERAND_STAGE -- requirements
Module: dispatch_operand_stage

---
 rtl/dispatch_operand_stage.sv | 220 ++++++++++++++++++++++
 tb/tb_dispatch_operand_stage.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_operand_stage.sv
// Dual-issue dispatch/operand stage: resolves register operands with EX/MEM
// forwarding, stalls on load-use, and splits dependent pairs through a one-entry slot.

module dos_operand_mux (
  input  logic        en_i,
  input  logic [4:0]  idx_i,
  input  logic [31:0] rf_data_i,
  input  logic [1:0]  ex_we_i,
  input  logic [1:0]  ex_is_load_i,
  input  logic [4:0]  ex_addr1_i,
  input  logic [4:0]  ex_addr2_i,
  input  logic [31:0] ex_data1_i,
  input  logic [31:0] ex_data2_i,
  input  logic [1:0]  mem_we_i,
  input  logic [4:0]  mem_addr1_i,
  input  logic [4:0]  mem_addr2_i,
  input  logic [31:0] mem_data1_i,
  input  logic [31:0] mem_data2_i,
  output logic [31:0] val_o,
  output logic        load_hit_o
);
  logic live, ex1, ex2, mem1, mem2;

  assign live = en_i && (idx_i != 5'd0);
  assign ex1  = ex_we_i[0]  && (ex_addr1_i  == idx_i);
  assign ex2  = ex_we_i[1]  && (ex_addr2_i  == idx_i);
  assign mem1 = mem_we_i[0] && (mem_addr1_i == idx_i);
  assign mem2 = mem_we_i[1] && (mem_addr2_i == idx_i);

  // Younger producers win: EX lane2 is the newest result in flight.
  always_comb begin
    val_o = 32'd0;
    if (!live)     val_o = 32'd0;
    else if (ex2)  val_o = ex_data2_i;
    else if (ex1)  val_o = ex_data1_i;
    else if (mem2) val_o = mem_data2_i;
    else if (mem1) val_o = mem_data1_i;
    else           val_o = rf_data_i;
  end

  assign load_hit_o = live && ((ex1 && ex_is_load_i[0]) || (ex2 && ex_is_load_i[1]));
endmodule

module dispatch_operand_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [1:0]  id_valid,
  output logic        id_ready,
  input  logic [31:0] id_pc1,
  input  logic [31:0] id_pc2,
  input  logic [1:0]  id_src_en1,
  input  logic [1:0]  id_src_en2,
  input  logic [4:0]  id_rj1,
  input  logic [4:0]  id_rk1,
  input  logic [4:0]  id_rj2,
  input  logic [4:0]  id_rk2,
  input  logic [4:0]  id_rd1,
  input  logic [4:0]  id_rd2,
  input  logic [1:0]  id_rd_we,
  output logic [1:0]  reg_read_en1,
  output logic [1:0]  reg_read_en2,
  output logic [4:0]  reg_read_addr1_1,
  output logic [4:0]  reg_read_addr1_2,
  output logic [4:0]  reg_read_addr2_1,
  output logic [4:0]  reg_read_addr2_2,
  input  logic [31:0] reg_read_data1_1,
  input  logic [31:0] reg_read_data1_2,
  input  logic [31:0] reg_read_data2_1,
  input  logic [31:0] reg_read_data2_2,
  input  logic [1:0]  ex_fwd_we,
  input  logic [4:0]  ex_fwd_addr1,
  input  logic [4:0]  ex_fwd_addr2,
  input  logic [31:0] ex_fwd_data1,
  input  logic [31:0] ex_fwd_data2,
  input  logic [1:0]  ex_fwd_is_load,
  input  logic [1:0]  mem_fwd_we,
  input  logic [4:0]  mem_fwd_addr1,
  input  logic [4:0]  mem_fwd_addr2,
  input  logic [31:0] mem_fwd_data1,
  input  logic [31:0] mem_fwd_data2,
  input  logic        ex_ready,
  output logic [1:0]  ex_valid,
  output logic [31:0] ex_pc1,
  output logic [31:0] ex_pc2,
  output logic [31:0] ex_src1_1,
  output logic [31:0] ex_src1_2,
  output logic [31:0] ex_src2_1,
  output logic [31:0] ex_src2_2,
  output logic [4:0]  ex_rd1,
  output logic [4:0]  ex_rd2,
  output logic [1:0]  ex_rd_we
);
  typedef enum logic {PAIR = 1'b0, SPLIT = 1'b1} state_e;

  state_e           state_q;
  logic             slot_v_q, slot_rd_we_q;
  logic [31:0]      slot_pc_q;
  logic [1:0]       slot_src_en_q;
  logic [4:0]       slot_rj_q, slot_rk_q, slot_rd_q;

  logic [1:0]       ex_valid_q, ex_rd_we_q;
  logic [1:0][31:0] ex_pc_q;
  logic [3:0][31:0] ex_src_q;
  logic [1:0][4:0]  ex_rd_q;

  // Presented lanes: in SPLIT the held instruction takes lane1 and lane2 is idle.
  logic        split, v1, v2, we1, dep, hazard, issue;
  logic [31:0] pc1;
  logic [1:0]  en1;
  logic [4:0]  rj1, rk1, rd1;

  assign split = (state_q == SPLIT);
  assign v1    = split ? slot_v_q      : id_valid[0];
  assign pc1   = split ? slot_pc_q     : id_pc1;
  assign en1   = split ? slot_src_en_q : id_src_en1;
  assign rj1   = split ? slot_rj_q     : id_rj1;
  assign rk1   = split ? slot_rk_q     : id_rk1;
  assign rd1   = split ? slot_rd_q     : id_rd1;
  assign we1   = split ? slot_rd_we_q  : id_rd_we[0];
  assign v2    = ~split & id_valid[1];

  assign reg_read_en1     = en1 & {2{v1}};
  assign reg_read_en2     = id_src_en2 & {2{v2}};
  assign reg_read_addr1_1 = rj1;
  assign reg_read_addr1_2 = rk1;
  assign reg_read_addr2_1 = id_rj2;
  assign reg_read_addr2_2 = id_rk2;

  logic [3:0]       op_en, op_hit;
  logic [3:0][4:0]  op_idx;
  logic [3:0][31:0] op_rf, op_val;

  assign op_en  = {reg_read_en2, reg_read_en1};
  assign op_idx = {id_rk2, id_rj2, rk1, rj1};
  assign op_rf  = {reg_read_data2_2, reg_read_data2_1, reg_read_data1_2, reg_read_data1_1};

  for (genvar g = 0; g < 4; g++) begin : g_op
    dos_operand_mux u_mux (
      .en_i         (op_en[g]),
      .idx_i        (op_idx[g]),
      .rf_data_i    (op_rf[g]),
      .ex_we_i      (ex_fwd_we),
      .ex_is_load_i (ex_fwd_is_load),
      .ex_addr1_i   (ex_fwd_addr1),
      .ex_addr2_i   (ex_fwd_addr2),
      .ex_data1_i   (ex_fwd_data1),
      .ex_data2_i   (ex_fwd_data2),
      .mem_we_i     (mem_fwd_we),
      .mem_addr1_i  (mem_fwd_addr1),
      .mem_addr2_i  (mem_fwd_addr2),
      .mem_data1_i  (mem_fwd_data1),
      .mem_data2_i  (mem_fwd_data2),
      .val_o        (op_val[g]),
      .load_hit_o   (op_hit[g])
    );
  end

  assign hazard = |op_hit;
  assign dep    = ~split && (id_valid == 2'b11) && id_rd_we[0] && (id_rd1 != 5'd0) &&
                  ((id_src_en2[0] && (id_rd1 == id_rj2)) || (id_src_en2[1] && (id_rd1 == id_rk2)));
  assign issue  = ex_ready && !hazard;
  assign id_ready = !flush && !split && issue;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= PAIR;
      slot_v_q      <= 1'b0;
      slot_pc_q     <= '0;
      slot_src_en_q <= '0;
      slot_rj_q     <= '0;
      slot_rk_q     <= '0;
      slot_rd_q     <= '0;
      slot_rd_we_q  <= 1'b0;
      ex_valid_q    <= '0;
      ex_pc_q       <= '0;
      ex_src_q      <= '0;
      ex_rd_q       <= '0;
      ex_rd_we_q    <= '0;
    end else if (flush) begin
      state_q    <= PAIR;
      slot_v_q   <= 1'b0;
      ex_valid_q <= '0;
    end else if (ex_ready) begin
      if (hazard) begin
        ex_valid_q <= '0;
      end else begin
        ex_valid_q <= {v2 & ~dep, v1};
        ex_pc_q    <= {id_pc2, pc1};
        ex_src_q   <= op_val;
        ex_rd_q    <= {id_rd2, rd1};
        ex_rd_we_q <= {id_rd_we[1], we1};
        if (dep) begin
          state_q       <= SPLIT;
          slot_v_q      <= 1'b1;
          slot_pc_q     <= id_pc2;
          slot_src_en_q <= id_src_en2;
          slot_rj_q     <= id_rj2;
          slot_rk_q     <= id_rk2;
          slot_rd_q     <= id_rd2;
          slot_rd_we_q  <= id_rd_we[1];
        end else if (split) begin
          state_q  <= PAIR;
          slot_v_q <= 1'b0;
        end
      end
    end
  end

  assign ex_valid  = ex_valid_q;
  assign ex_pc1    = ex_pc_q[0];
  assign ex_pc2    = ex_pc_q[1];
  assign ex_src1_1 = ex_src_q[0];
  assign ex_src1_2 = ex_src_q[1];
  assign ex_src2_1 = ex_src_q[2];
  assign ex_src2_2 = ex_src_q[3];
  assign ex_rd1    = ex_rd_q[0];
  assign ex_rd2    = ex_rd_q[1];
  assign ex_rd_we  = ex_rd_we_q;
endmodule

// File: tb/tb_dispatch_operand_stage.sv
// Randomized bench for dispatch_operand_stage against a queue-based instruction model,
// with directed cases pinning forwarding, load-use, split, stall, flush and reset.

module tb_dispatch_operand_stage;
  logic        clk = 1'b0, rst = 1'b0, flush;
  logic [1:0]  id_valid, id_src_en1, id_src_en2, id_rd_we;
  logic        id_ready;
  logic [31:0] id_pc1, id_pc2;
  logic [4:0]  id_rj1, id_rk1, id_rj2, id_rk2, id_rd1, id_rd2;
  logic [1:0]  reg_read_en1, reg_read_en2;
  logic [4:0]  reg_read_addr1_1, reg_read_addr1_2, reg_read_addr2_1, reg_read_addr2_2;
  logic [31:0] reg_read_data1_1, reg_read_data1_2, reg_read_data2_1, reg_read_data2_2;
  logic [1:0]  ex_fwd_we, ex_fwd_is_load, mem_fwd_we;
  logic [4:0]  ex_fwd_addr1, ex_fwd_addr2, mem_fwd_addr1, mem_fwd_addr2;
  logic [31:0] ex_fwd_data1, ex_fwd_data2, mem_fwd_data1, mem_fwd_data2;
  logic        ex_ready;
  logic [1:0]  ex_valid, ex_rd_we;
  logic [31:0] ex_pc1, ex_pc2, ex_src1_1, ex_src1_2, ex_src2_1, ex_src2_2;
  logic [4:0]  ex_rd1, ex_rd2;

  logic [31:0] rf [32];
  assign reg_read_data1_1 = rf[reg_read_addr1_1];
  assign reg_read_data1_2 = rf[reg_read_addr1_2];
  assign reg_read_data2_1 = rf[reg_read_addr2_1];
  assign reg_read_data2_2 = rf[reg_read_addr2_2];

  always #5 clk = ~clk;

  dispatch_operand_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc1(id_pc1), .id_pc2(id_pc2), .id_src_en1(id_src_en1), .id_src_en2(id_src_en2),
    .id_rj1(id_rj1), .id_rk1(id_rk1), .id_rj2(id_rj2), .id_rk2(id_rk2),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_rd_we(id_rd_we),
    .reg_read_en1(reg_read_en1), .reg_read_en2(reg_read_en2),
    .reg_read_addr1_1(reg_read_addr1_1), .reg_read_addr1_2(reg_read_addr1_2),
    .reg_read_addr2_1(reg_read_addr2_1), .reg_read_addr2_2(reg_read_addr2_2),
    .reg_read_data1_1(reg_read_data1_1), .reg_read_data1_2(reg_read_data1_2),
    .reg_read_data2_1(reg_read_data2_1), .reg_read_data2_2(reg_read_data2_2),
    .ex_fwd_we(ex_fwd_we), .ex_fwd_addr1(ex_fwd_addr1), .ex_fwd_addr2(ex_fwd_addr2),
    .ex_fwd_data1(ex_fwd_data1), .ex_fwd_data2(ex_fwd_data2), .ex_fwd_is_load(ex_fwd_is_load),
    .mem_fwd_we(mem_fwd_we), .mem_fwd_addr1(mem_fwd_addr1), .mem_fwd_addr2(mem_fwd_addr2),
    .mem_fwd_data1(mem_fwd_data1), .mem_fwd_data2(mem_fwd_data2),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc1(ex_pc1), .ex_pc2(ex_pc2),
    .ex_src1_1(ex_src1_1), .ex_src1_2(ex_src1_2), .ex_src2_1(ex_src2_1), .ex_src2_2(ex_src2_2),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_rd_we(ex_rd_we)
  );

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [1:0]  en;
    logic [4:0]  rj, rk, rd;
    logic        we;
  } ins_t;

  int n_pass = 0, n_tot = 0;

  // Model state: instructions waiting to dispatch, plus what EX must show.
  ins_t        held[$];
  logic [1:0]  m_v, m_we;
  logic [31:0] m_pc [2];
  logic [31:0] m_src [4];
  logic [4:0]  m_rd [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] operand(input logic en, input logic [4:0] idx);
    logic        w [4];
    logic [4:0]  a [4];
    logic [31:0] d [4];
    w = '{ex_fwd_we[1], ex_fwd_we[0], mem_fwd_we[1], mem_fwd_we[0]};
    a = '{ex_fwd_addr2, ex_fwd_addr1, mem_fwd_addr2, mem_fwd_addr1};
    d = '{ex_fwd_data2, ex_fwd_data1, mem_fwd_data2, mem_fwd_data1};
    if (!en || idx == 5'd0) return 32'd0;
    for (int k = 0; k < 4; k++) if (w[k] && a[k] == idx) return d[k];
    return rf[idx];
  endfunction

  function automatic logic is_load_src(input logic en, input logic [4:0] idx);
    if (!en || idx == 5'd0) return 1'b0;
    return (ex_fwd_we[0] && ex_fwd_is_load[0] && ex_fwd_addr1 == idx) ||
           (ex_fwd_we[1] && ex_fwd_is_load[1] && ex_fwd_addr2 == idx);
  endfunction

  task automatic model_reset();
    held.delete();
    m_v = '0; m_we = '0;
    for (int i = 0; i < 2; i++) begin m_pc[i] = '0; m_rd[i] = '0; end
    for (int i = 0; i < 4; i++) m_src[i] = '0;
  endtask

  task automatic check_outputs();
    chk("ex_valid", 32'(ex_valid), 32'(m_v));
    if (m_v[0]) begin
      chk("ex_pc1", ex_pc1, m_pc[0]);   chk("ex_src1_1", ex_src1_1, m_src[0]);
      chk("ex_src1_2", ex_src1_2, m_src[1]); chk("ex_rd1", 32'(ex_rd1), 32'(m_rd[0]));
      chk("ex_rd_we1", 32'(ex_rd_we[0]), 32'(m_we[0]));
    end
    if (m_v[1]) begin
      chk("ex_pc2", ex_pc2, m_pc[1]);   chk("ex_src2_1", ex_src2_1, m_src[2]);
      chk("ex_src2_2", ex_src2_2, m_src[3]); chk("ex_rd2", 32'(ex_rd2), 32'(m_rd[1]));
      chk("ex_rd_we2", 32'(ex_rd_we[1]), 32'(m_we[1]));
    end
  endtask

  // Inputs are already driven; check the combinational side, step one edge, check EX.
  task automatic cycle();
    ins_t l1, l2;
    logic haz, dep;
    logic [31:0] s [4];
    #1;
    l2 = '{v: id_valid[1], pc: id_pc2, en: id_src_en2, rj: id_rj2, rk: id_rk2, rd: id_rd2, we: id_rd_we[1]};
    if (held.size() != 0) begin l1 = held[0]; l2.v = 1'b0; end
    else l1 = '{v: id_valid[0], pc: id_pc1, en: id_src_en1, rj: id_rj1, rk: id_rk1, rd: id_rd1, we: id_rd_we[0]};
    if (!l1.v) l1.en = 2'b00;
    if (!l2.v) l2.en = 2'b00;
    s[0] = operand(l1.en[0], l1.rj); s[1] = operand(l1.en[1], l1.rk);
    s[2] = operand(l2.en[0], l2.rj); s[3] = operand(l2.en[1], l2.rk);
    haz = is_load_src(l1.en[0], l1.rj) || is_load_src(l1.en[1], l1.rk) ||
          is_load_src(l2.en[0], l2.rj) || is_load_src(l2.en[1], l2.rk);
    dep = l1.v && l2.v && l1.we && l1.rd != 0 &&
          ((l2.en[0] && l2.rj == l1.rd) || (l2.en[1] && l2.rk == l1.rd));
    chk("id_ready", 32'(id_ready), 32'(!flush && held.size() == 0 && ex_ready && !haz));
    chk("reg_read_en1", 32'(reg_read_en1), 32'(l1.en));
    chk("reg_read_en2", 32'(reg_read_en2), 32'(l2.en));
    if (l1.en[0]) chk("reg_read_addr1_1", 32'(reg_read_addr1_1), 32'(l1.rj));
    if (l1.en[1]) chk("reg_read_addr1_2", 32'(reg_read_addr1_2), 32'(l1.rk));
    if (l2.en[0]) chk("reg_read_addr2_1", 32'(reg_read_addr2_1), 32'(l2.rj));
    if (l2.en[1]) chk("reg_read_addr2_2", 32'(reg_read_addr2_2), 32'(l2.rk));
    @(posedge clk);
    if (flush) begin
      m_v = 2'b00; held.delete();
    end else if (ex_ready) begin
      if (haz) m_v = 2'b00;
      else begin
        m_v = {l2.v && !dep, l1.v};
        m_pc[0] = l1.pc; m_pc[1] = l2.pc; m_rd[0] = l1.rd; m_rd[1] = l2.rd;
        m_we = {l2.we, l1.we};
        for (int i = 0; i < 4; i++) m_src[i] = s[i];
        held.delete();
        if (dep) held.push_back(l2);
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_idle();
    flush = 0; ex_ready = 1; id_valid = 0; id_pc1 = 0; id_pc2 = 0;
    id_src_en1 = 0; id_src_en2 = 0; id_rj1 = 0; id_rk1 = 0; id_rj2 = 0; id_rk2 = 0;
    id_rd1 = 0; id_rd2 = 0; id_rd_we = 0;
    ex_fwd_we = 0; ex_fwd_is_load = 0; ex_fwd_addr1 = 0; ex_fwd_addr2 = 0;
    ex_fwd_data1 = 0; ex_fwd_data2 = 0;
    mem_fwd_we = 0; mem_fwd_addr1 = 0; mem_fwd_addr2 = 0; mem_fwd_data1 = 0; mem_fwd_data2 = 0;
  endtask

  task automatic set_split_pair();
    set_idle();
    id_valid = 2'b11; id_pc1 = 32'h100; id_pc2 = 32'h104;
    id_rd1 = 5'd9; id_rd_we = 2'b01; id_src_en2 = 2'b01; id_rj2 = 5'd9;
  endtask

  task automatic rand_inputs();
    id_valid   = 2'($urandom_range(0, 3));
    id_pc1     = $urandom; id_pc2 = $urandom;
    id_src_en1 = 2'($urandom_range(0, 3)); id_src_en2 = 2'($urandom_range(0, 3));
    id_rj1 = 5'($urandom_range(0, 7)); id_rk1 = 5'($urandom_range(0, 7));
    id_rj2 = 5'($urandom_range(0, 7)); id_rk2 = 5'($urandom_range(0, 7));
    id_rd1 = 5'($urandom_range(0, 7)); id_rd2 = 5'($urandom_range(0, 7));
    id_rd_we  = 2'($urandom_range(0, 3));
    ex_fwd_we = 2'($urandom_range(0, 3));
    ex_fwd_is_load = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    ex_fwd_addr1 = 5'($urandom_range(0, 7)); ex_fwd_addr2 = 5'($urandom_range(0, 7));
    ex_fwd_data1 = $urandom; ex_fwd_data2 = $urandom;
    mem_fwd_we = 2'($urandom_range(0, 3));
    mem_fwd_addr1 = 5'($urandom_range(0, 7)); mem_fwd_addr2 = 5'($urandom_range(0, 7));
    mem_fwd_data1 = $urandom; mem_fwd_data2 = $urandom;
    ex_ready = ($urandom_range(0, 4) != 0);
    flush    = ($urandom_range(0, 19) == 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'hDEAD_0000;
    rf[3] = 32'd5;
    set_idle();
    model_reset();
    #1 rst = 1'b1;
    #1;
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_ex_pc1", ex_pc1, 32'd0);
    chk("rst_ex_src2_2", ex_src2_2, 32'd0);
    chk("rst_ex_rd_we", 32'(ex_rd_we), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Independent pair reading r3 on lane1 rj and lane2 rk.
    set_idle();
    id_valid = 2'b11; id_src_en1 = 2'b01; id_rj1 = 5'd3; id_src_en2 = 2'b10; id_rk2 = 5'd3;
    id_pc1 = 32'h10; id_pc2 = 32'h14;
    cycle();
    chk("pair_valid", 32'(ex_valid), 32'd3);
    chk("pair_src1_1", ex_src1_1, 32'd5);
    chk("pair_src2_2", ex_src2_2, 32'd5);

    // Forward priority on r7: EX1 beats MEM2, then EX2 beats EX1.
    set_idle();
    id_valid = 2'b01; id_src_en1 = 2'b01; id_rj1 = 5'd7;
    ex_fwd_we = 2'b01; ex_fwd_addr1 = 5'd7; ex_fwd_data1 = 32'hA;
    mem_fwd_we = 2'b10; mem_fwd_addr2 = 5'd7; mem_fwd_data2 = 32'hB;
    cycle();
    chk("fwd_ex1_over_mem2", ex_src1_1, 32'hA);
    ex_fwd_we = 2'b11; ex_fwd_addr2 = 5'd7; ex_fwd_data2 = 32'hC;
    cycle();
    chk("fwd_ex2_over_ex1", ex_src1_1, 32'hC);
    id_rj1 = 5'd0; ex_fwd_addr2 = 5'd0;
    cycle();
    chk("fwd_r0_zero", ex_src1_1, 32'd0);

    // Load-use on r4, then the value arrives from MEM.
    set_idle();
    id_valid = 2'b01; id_src_en1 = 2'b01; id_rj1 = 5'd4; id_pc1 = 32'h40;
    ex_fwd_we = 2'b01; ex_fwd_is_load = 2'b01; ex_fwd_addr1 = 5'd4;
    #1 chk("lu_id_ready", 32'(id_ready), 32'd0);
    cycle();
    chk("lu_bubble", 32'(ex_valid), 32'd0);
    ex_fwd_we = 2'b00; ex_fwd_is_load = 2'b00;
    mem_fwd_we = 2'b01; mem_fwd_addr1 = 5'd4; mem_fwd_data1 = 32'h44;
    #1 chk("lu_release", 32'(id_ready), 32'd1);
    cycle();
    chk("lu_valid", 32'(ex_valid), 32'd1);
    chk("lu_mem_fwd", ex_src1_1, 32'h44);

    // Intra-pair dependency through r9.
    set_split_pair();
    cycle();
    chk("dep_c1_valid", 32'(ex_valid), 32'd1);
    chk("dep_c1_pc", ex_pc1, 32'h100);
    id_pc1 = 32'h200; id_pc2 = 32'h204;
    ex_fwd_we = 2'b01; ex_fwd_addr1 = 5'd9; ex_fwd_data1 = 32'h99;
    #1 chk("dep_split_ready", 32'(id_ready), 32'd0);
    chk("dep_split_en2", 32'(reg_read_en2), 32'd0);
    cycle();
    chk("dep_c2_valid", 32'(ex_valid), 32'd1);
    chk("dep_c2_pc", ex_pc1, 32'h104);
    chk("dep_c2_fwd", ex_src1_1, 32'h99);

    // Lone lane2 issues on output lane2.
    set_idle();
    id_valid = 2'b10; id_src_en2 = 2'b01; id_rj2 = 5'd3; id_pc2 = 32'h300;
    cycle();
    chk("lone2_valid", 32'(ex_valid), 32'd2);
    chk("lone2_pc", ex_pc2, 32'h300);
    chk("lone2_src", ex_src2_1, 32'd5);

    // Three-cycle stall holds outputs.
    set_idle();
    id_valid = 2'b11; id_pc1 = 32'h500; id_pc2 = 32'h504;
    cycle();
    for (int i = 0; i < 3; i++) begin
      rand_inputs(); flush = 0; ex_ready = 0;
      #1 chk("stall_ready", 32'(id_ready), 32'd0);
      cycle();
      chk("stall_valid", 32'(ex_valid), 32'd3);
      chk("stall_pc1", ex_pc1, 32'h500);
    end

    // Flush while split.
    set_split_pair();
    cycle();
    flush = 1;
    #1 chk("flush_ready", 32'(id_ready), 32'd0);
    cycle();
    chk("flush_valid", 32'(ex_valid), 32'd0);
    set_idle();
    #1 chk("post_flush_ready", 32'(id_ready), 32'd1);
    cycle();
    ex_ready = 0;
    #1 chk("post_flush_follow", 32'(id_ready), 32'd0);
    cycle();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      cycle();
    end

    // Asynchronous reset while split.
    set_split_pair();
    cycle();
    #2 rst = 1'b1;
    #1 chk("arst_valid", 32'(ex_valid), 32'd0);
    chk("arst_pc1", ex_pc1, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    set_idle();
    #1 chk("arst_ready", 32'(id_ready), 32'd1);
    chk("arst_no_slot", 32'(reg_read_en1), 32'd0);
    cycle();
    chk("arst_no_stale", 32'(ex_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
